button_bank: RTL and testbench



---
 rtl/button_bank.sv | 124 ++++++++++++
 tb/tb_button_bank.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/button_bank.sv
// Multi-channel push-button conditioner: per channel a synchroniser, symmetric
// debouncer, press/release pulses, long-press detection and auto-repeat.
module button_bank #(
   parameter int NUM_CH          = 4,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int HOLD_CYCLES     = 25000000,
   parameter int REPEAT_CYCLES   = 5000000,
   parameter int ACTIVE_LOW      = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] button,
   output logic [NUM_CH-1:0] pressed,
   output logic [NUM_CH-1:0] press_pulse,
   output logic [NUM_CH-1:0] release_pulse,
   output logic [NUM_CH-1:0] long_pulse,
   output logic [NUM_CH-1:0] held,
   output logic [NUM_CH-1:0] repeat_pulse
);

   localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int HW_H = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int HW_R = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
   localparam int HW   = (HW_H > HW_R) ? HW_H : HW_R;

   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [DW-1:0] D_ONE     = DW'(1);
   localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
   localparam logic [HW-1:0] REP_LAST  = HW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
   localparam logic [HW-1:0] H_ONE     = HW'(1);
   localparam logic          HOLD_EN   = (HOLD_CYCLES > 0) ? 1'b1 : 1'b0;
   localparam logic          REP_EN    = (REPEAT_CYCLES > 0) ? 1'b1 : 1'b0;
   localparam logic          POL       = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q, sync_d;
      logic [DW-1:0]          dcnt_q, dcnt_d;
      logic [HW-1:0]          hcnt_q, hcnt_d;
      logic pressed_q, pressed_d, press_q, press_d, rel_q, rel_d;
      logic long_q, long_d, held_q, held_d, rep_q, rep_d;
      logic s;

      assign s = sync_q[SYNC_STAGES-1];

      always_comb begin
         sync_d    = {sync_q[SYNC_STAGES-2:0], button[i] ^ POL};
         dcnt_d    = dcnt_q;
         pressed_d = pressed_q;
         press_d   = 1'b0;
         rel_d     = 1'b0;
         hcnt_d    = hcnt_q;
         held_d    = held_q;
         long_d    = 1'b0;
         rep_d     = 1'b0;

         // Any sample matching the accepted level restarts the stability count.
         if (s == pressed_q) begin
            dcnt_d = '0;
         end else if (dcnt_q == DEB_LAST) begin
            dcnt_d    = '0;
            pressed_d = ~pressed_q;
            press_d   = ~pressed_q;
            rel_d     = pressed_q;
         end else begin
            dcnt_d = dcnt_q + D_ONE;
         end

         // Hold timing runs only while pressed stays high across the edge, so
         // the press edge keeps hcnt at 0 and the release edge swallows pulses.
         if (!(pressed_q && pressed_d) || !HOLD_EN) begin
            hcnt_d = '0;
            held_d = 1'b0;
         end else if (!held_q) begin
            if (hcnt_q == HOLD_LAST) begin
               long_d = 1'b1;
               held_d = 1'b1;
               hcnt_d = '0;
            end else begin
               hcnt_d = hcnt_q + H_ONE;
            end
         end else if (!REP_EN) begin
            hcnt_d = hcnt_q;
         end else if (hcnt_q == REP_LAST) begin
            rep_d  = 1'b1;
            hcnt_d = '0;
         end else begin
            hcnt_d = hcnt_q + H_ONE;
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            sync_q    <= '0;
            dcnt_q    <= '0;
            hcnt_q    <= '0;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            rel_q     <= 1'b0;
            long_q    <= 1'b0;
            held_q    <= 1'b0;
            rep_q     <= 1'b0;
         end else begin
            sync_q    <= sync_d;
            dcnt_q    <= dcnt_d;
            hcnt_q    <= hcnt_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            rel_q     <= rel_d;
            long_q    <= long_d;
            held_q    <= held_d;
            rep_q     <= rep_d;
         end
      end

      assign pressed[i]       = pressed_q;
      assign press_pulse[i]   = press_q;
      assign release_pulse[i] = rel_q;
      assign long_pulse[i]    = long_q;
      assign held[i]          = held_q;
      assign repeat_pulse[i]  = rep_q;
   end

endmodule

// File: tb/tb_button_bank.sv
// Bench for button_bank: scenario table turned into per-edge expected outputs
// via the latency/hold/repeat timing formulas, checked on two polarity builds.
module tb_button_bank;
   localparam int NUM_CH = 4;
   localparam int HOLD   = 10;
   localparam int REP    = 3;
   localparam int OW     = 6 * NUM_CH;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic [NUM_CH-1:0] button, button_al;
   logic [NUM_CH-1:0] pressed, press_pulse, release_pulse, long_pulse, held, repeat_pulse;
   logic [NUM_CH-1:0] pressed_a, press_pulse_a, release_pulse_a, long_pulse_a, held_a, repeat_pulse_a;

   button_bank #(.NUM_CH(NUM_CH), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
                 .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .ACTIVE_LOW(0)) dut (
      .clk(clk), .rst(rst), .button(button), .pressed(pressed),
      .press_pulse(press_pulse), .release_pulse(release_pulse),
      .long_pulse(long_pulse), .held(held), .repeat_pulse(repeat_pulse));

   button_bank #(.NUM_CH(NUM_CH), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
                 .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .ACTIVE_LOW(1)) dut_al (
      .clk(clk), .rst(rst), .button(button_al), .pressed(pressed_a),
      .press_pulse(press_pulse_a), .release_pulse(release_pulse_a),
      .long_pulse(long_pulse_a), .held(held_a), .repeat_pulse(repeat_pulse_a));

   logic [OW-1:0] act_main, act_al;
   assign act_main = {pressed, press_pulse, release_pulse, long_pulse, held, repeat_pulse};
   assign act_al   = {pressed_a, press_pulse_a, release_pulse_a, long_pulse_a, held_a, repeat_pulse_a};

   // p/r: edge of accepted press/release relative to scenario edge 0 (8'hFF = never)
   typedef struct {
      string                    name;
      int                       len;
      logic [NUM_CH-1:0][63:0]  raw;
      logic [NUM_CH-1:0][7:0]   p;
      logic [NUM_CH-1:0][7:0]   r;
   } vec_t;

   typedef struct {
      string         name;
      int            edge_n;
      logic [OW-1:0] exp;
   } sb_t;

   vec_t vecs[9];
   sb_t  sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic logic [63:0] pulse(int on, int off);
      logic [63:0] v;
      v = '0;
      for (int b = 0; b < 64; b++) if (b >= on && b < off) v[b] = 1'b1;
      return v;
   endfunction

   function automatic logic [OW-1:0] expect_at(vec_t v, int e);
      logic [NUM_CH-1:0] pr, pp, rp, lp, hd, rt;
      int P, R;
      pr = '0; pp = '0; rp = '0; lp = '0; hd = '0; rt = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         P = int'(v.p[c]);
         R = int'(v.r[c]);
         pr[c] = (e >= P) && (e < R);
         pp[c] = (e == P);
         rp[c] = (e == R);
         lp[c] = (e == P + HOLD) && (e < R);
         hd[c] = (e >= P + HOLD) && (e < R);
         rt[c] = (e > P + HOLD) && (e < R) && (((e - P - HOLD) % REP) == 0);
      end
      return {pr, pp, rp, lp, hd, rt};
   endfunction

   task automatic check(string name, logic [OW-1:0] got, logic [OW-1:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   task automatic new_vec(int idx, string name, int len);
      vecs[idx].name = name;
      vecs[idx].len  = len;
      vecs[idx].raw  = '0;
      vecs[idx].p    = {NUM_CH{8'hFF}};
      vecs[idx].r    = {NUM_CH{8'hFF}};
   endtask

   task automatic set_ch(int idx, int c, logic [63:0] raw, int p, int r);
      vecs[idx].raw[c] = raw;
      vecs[idx].p[c]   = 8'(p);
      vecs[idx].r[c]   = 8'(r);
   endtask

   task automatic run_vec(vec_t v);
      for (int e = 0; e < v.len; e++) begin
         for (int c = 0; c < NUM_CH; c++) button[c] = v.raw[c][e];
         button_al = ~button;
         sb_q.push_back('{name: v.name, edge_n: e, exp: expect_at(v, e)});
         @(posedge clk);
         @(negedge clk);
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s@%0d: scoreboard empty, expected one entry", v.name, e);
         end else begin
            sb_t it;
            it = sb_q.pop_front();
            check($sformatf("%s@%0d", it.name, it.edge_n), act_main, it.exp);
            check($sformatf("%s@%0d active_low", it.name, it.edge_n), act_al, it.exp);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      new_vec(0, "powerup", 18);   set_ch(0, 1, pulse(0, 8), 5, 13);
      new_vec(1, "clean", 30);     set_ch(1, 0, pulse(0, 20), 5, 25);
      new_vec(2, "bounce", 22);    set_ch(2, 1, pulse(0, 3) | pulse(4, 12), 9, 17);
      new_vec(3, "long_rep", 40);  set_ch(3, 2, pulse(0, 30), 5, 35);
      new_vec(4, "rel_on_rep", 22); set_ch(4, 2, pulse(0, 13), 5, 18);
      new_vec(5, "simult", 18);
      set_ch(5, 0, pulse(0, 8), 5, 13);
      set_ch(5, 3, pulse(0, 8), 5, 13);
      set_ch(5, 1, pulse(2, 9), 7, 14);
      new_vec(6, "min_stable", 14);
      set_ch(6, 2, pulse(0, 4), 5, 9);
      set_ch(6, 3, pulse(0, 3), 255, 255);
      new_vec(7, "pre_reset", 17); set_ch(7, 2, pulse(0, 64), 5, 255);
      new_vec(8, "post_reset", 30); set_ch(8, 2, pulse(0, 20), 5, 25);

      // Power-up with channel 1 already active during reset.
      rst       = 1'b1;
      button    = 4'b0010;
      button_al = ~button;
      repeat (3) @(negedge clk);
      check("reset_state", act_main, '0);
      check("reset_state active_low", act_al, '0);
      rst = 1'b0;

      for (int k = 0; k < 8; k++) run_vec(vecs[k]);

      // Reset while pressed and held, button kept high throughout.
      rst = 1'b1;
      #1;
      check("reset_async", act_main, '0);
      check("reset_async active_low", act_al, '0);
      repeat (2) begin
         @(negedge clk);
         check("reset_hold", act_main, '0);
         check("reset_hold active_low", act_al, '0);
      end
      rst = 1'b0;
      run_vec(vecs[8]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
